// File: rtl/ntt_pkg.sv
// Constants shared by the forward/inverse NTT processing elements and the schedulers.
package ntt_pkg;
  localparam int MOD_Q         = 3329;
  localparam int DATA_W        = 12;
  localparam int BF_LAT        = 6;
  localparam int BF_HALF_STAGE = 3;
endpackage

// File: rtl/intt_bf_half_mod_half_q.sv
// mod_half_q: combinational x * 2^-1 mod q for canonical x; q must be odd.
module mod_half_q #(
  parameter int data_width = ntt_pkg::DATA_W,
  parameter int MOD_Q      = ntt_pkg::MOD_Q
) (
  input  logic [data_width-1:0] x,
  output logic [data_width-1:0] y
);
  localparam logic [data_width:0] Q_EXT = (data_width+1)'(MOD_Q);

  logic [data_width:0] x_even;

  // An odd x becomes even by adding the odd modulus; the extra bit holds the carry.
  always_comb begin
    x_even = {1'b0, x} + (x[0] ? Q_EXT : '0);
    y      = data_width'(x_even >> 1);
  end
endmodule

// File: rtl/intt_bf_half.sv
// Inverse (Gentleman-Sande) butterfly producing (u+v)/2 and (u-v)/2 mod q, 6-cycle latency.
// Optional macro INTT_BF_STALL_EN adds an 'en' port that freezes the whole pipeline.
module intt_bf_half
  import ntt_pkg::DATA_W;
  import ntt_pkg::BF_HALF_STAGE;
#(
  parameter int data_width = DATA_W,
  parameter int MOD_Q      = ntt_pkg::MOD_Q
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef INTT_BF_STALL_EN
  input  logic                  en,
`endif
  input  logic                  valid_in,
  input  logic                  sel,
  input  logic [data_width-1:0] u,
  input  logic [data_width-1:0] v,
  output logic                  valid_out,
  output logic [data_width-1:0] bf_upper,
  output logic [data_width-1:0] bf_lower
);
  localparam int                  NS    = BF_HALF_STAGE;
  localparam logic [data_width:0] Q_EXT = (data_width+1)'(MOD_Q);
  localparam logic [data_width-1:0] Q_W = data_width'(MOD_Q);

  logic adv;
`ifdef INTT_BF_STALL_EN
  assign adv = en;
`else
  assign adv = 1'b1;
`endif

  logic [data_width-1:0] u_pipe [NS];
  logic [data_width-1:0] v_pipe [NS];
  logic [NS-1:0]         sel_pipe;
  logic [NS-1:0]         vin_pipe;

  logic [data_width-1:0] up_pipe [NS];
  logic [data_width-1:0] lo_pipe [NS];
  logic [NS-1:0]         vout_pipe;

  logic [data_width:0]   sum_raw;
  logic [data_width-1:0] sum_mod, diff_mod, sum_half, diff_half, up_nxt, lo_nxt;

  // Modular add/sub between the two register halves; diff wraps in data_width bits
  // and adding q back lands exactly in [1, q-1] when u < v.
  always_comb begin
    sum_raw  = {1'b0, u_pipe[NS-1]} + {1'b0, v_pipe[NS-1]};
    sum_mod  = (sum_raw >= Q_EXT) ? data_width'(sum_raw - Q_EXT) : data_width'(sum_raw);
    diff_mod = u_pipe[NS-1] - v_pipe[NS-1] + ((u_pipe[NS-1] < v_pipe[NS-1]) ? Q_W : '0);
    up_nxt   = sel_pipe[NS-1] ? sum_half  : sum_mod;
    lo_nxt   = sel_pipe[NS-1] ? diff_half : diff_mod;
  end

  mod_half_q #(.data_width(data_width), .MOD_Q(MOD_Q)) u_half_sum (
    .x (sum_mod),
    .y (sum_half)
  );

  mod_half_q #(.data_width(data_width), .MOD_Q(MOD_Q)) u_half_diff (
    .x (diff_mod),
    .y (diff_half)
  );

  // Data stages load every advancing cycle regardless of valid; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        u_pipe[i]  <= '0;
        v_pipe[i]  <= '0;
        up_pipe[i] <= '0;
        lo_pipe[i] <= '0;
      end
      sel_pipe  <= '0;
      vin_pipe  <= '0;
      vout_pipe <= '0;
    end else if (adv) begin
      u_pipe[0]  <= u;
      v_pipe[0]  <= v;
      up_pipe[0] <= up_nxt;
      lo_pipe[0] <= lo_nxt;
      for (int i = 1; i < NS; i++) begin
        u_pipe[i]  <= u_pipe[i-1];
        v_pipe[i]  <= v_pipe[i-1];
        up_pipe[i] <= up_pipe[i-1];
        lo_pipe[i] <= lo_pipe[i-1];
      end
      sel_pipe  <= {sel_pipe[NS-2:0], sel};
      vin_pipe  <= {vin_pipe[NS-2:0], valid_in};
      vout_pipe <= {vout_pipe[NS-2:0], vin_pipe[NS-1]};
    end
  end

  assign valid_out = vout_pipe[NS-1];
  assign bf_upper  = up_pipe[NS-1];
  assign bf_lower  = lo_pipe[NS-1];
endmodule
